// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the BCD display scanner: segment codes, widths and FSM states.
package bcd_display_scan_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_ERR   = 7'h06;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Converter-to-display bundle: load strobe with BCD payload in, scanned display drive out.
interface bcd_display_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic              load;
    logic [4*NDIG-1:0] bcd_in;
    logic              neg_in;
    logic              eq_in;
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    logic              dp;
    logic              shown;

    modport master (
        output load, bcd_in, neg_in, eq_in,
        input  an, seg, dp, shown
    );

    modport slave (
        input  load, bcd_in, neg_in, eq_in,
        output an, seg, dp, shown
    );
endinterface

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// One BCD digit to active-low seven-segment code; minus overrides blank, digits >9 show 'E'.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_blank,
    input  logic               i_minus,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_ERR;
        if (i_minus) begin
            o_seg_c = SEG_MINUS;
        end else if (i_blank) begin
            o_seg_c = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg_c = SEG_0;
                4'd1:    o_seg_c = SEG_1;
                4'd2:    o_seg_c = SEG_2;
                4'd3:    o_seg_c = SEG_3;
                4'd4:    o_seg_c = SEG_4;
                4'd5:    o_seg_c = SEG_5;
                4'd6:    o_seg_c = SEG_6;
                4'd7:    o_seg_c = SEG_7;
                4'd8:    o_seg_c = SEG_8;
                4'd9:    o_seg_c = SEG_9;
                default: o_seg_c = SEG_ERR;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Snapshots a BCD value on load and scans it onto a common-anode display with
// leading-zero blanking, sign placement and invalid-digit flagging.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_display_scan_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NDIG);
    localparam int unsigned PRE_W = $clog2(PRESCALE);
    localparam int unsigned BCD_W = DIGIT_W * NDIG;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_neg;
    logic                r_eq;
    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic                w_tc;
    logic                w_zero_run;
    logic [NDIG-1:0]     w_blank;
    logic [NDIG-1:0]     w_minus;
    logic [DIGIT_W-1:0]  w_digit;
    logic                w_digit_blank;
    logic                w_digit_minus;
    logic [SEG_W-1:0]    w_seg_c;
    logic [NDIG-1:0]     w_an_nxt;
    logic [SEG_W-1:0]    w_seg_nxt;
    logic                w_dp_nxt;
    logic [NDIG-1:0]     r_an;
    logic [SEG_W-1:0]    r_seg;
    logic                r_dp;
    logic                r_shown;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_neg <= 1'b0;
            r_eq  <= 1'b0;
        end else if (bus.load) begin
            r_bcd <= bus.bcd_in;
            r_neg <= bus.neg_in;
            r_eq  <= bus.eq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot timer and digit pointer run only while scanning; reloads leave them alone.
    assign w_tc = (r_pre == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SCAN)) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Blanking runs down from the top while digits are zero; the sign sits just above the number.
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        w_minus    = '0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_bcd[DIGIT_W*i +: DIGIT_W] == 4'd0);
            w_blank[i] = w_zero_run && (i != 0);
        end
        for (int i = 1; i < int'(NDIG); i++) begin
            w_minus[i] = r_neg && w_blank[i] && !w_blank[i-1];
        end
    end

    always_comb begin
        w_digit       = '0;
        w_digit_blank = 1'b0;
        w_digit_minus = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit       = r_bcd[DIGIT_W*i +: DIGIT_W];
                w_digit_blank = w_blank[i];
                w_digit_minus = w_minus[i];
            end
        end
    end

    bcd_to_seg7 u_seg7 (
        .i_digit (w_digit),
        .i_blank (w_digit_blank),
        .i_minus (w_digit_minus),
        .o_seg_c (w_seg_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = '1;
        w_seg_nxt   = SEG_BLANK;
        w_dp_nxt    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_an_nxt  = ~(NDIG'(1) << r_idx);
                w_seg_nxt = w_seg_c;
                w_dp_nxt  = !((r_idx == '0) && r_eq);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an    <= '1;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
            r_shown <= 1'b0;
        end else begin
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_shown <= (w_state_nxt == ST_SCAN);
        end
    end

    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
    assign bus.dp    = r_dp;
    assign bus.shown = r_shown;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with NDIG=4, PRESCALE=4.
module tb_bcd_display_scan;

    localparam int unsigned NDIG     = 4;
    localparam int unsigned PRESCALE = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   t0;
    logic [6:0] exp_seg [4];
    logic       exp_eq;

    bcd_display_scan_if #(.NDIG(NDIG)) bus ();

    bcd_display_scan #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_an"},    {4'h0, bus.an}, 8'h0F);
        cmp({tag, "_seg"},   {1'b0, bus.seg}, 8'h7F);
        cmp({tag, "_dp"},    {7'h0, bus.dp}, 8'h01);
        cmp({tag, "_shown"}, {7'h0, bus.shown}, 8'h00);
    endtask

    // Displayed digit follows a fixed schedule anchored at the first scanned output cycle.
    task automatic check_scan(input string tag);
        int         d;
        logic [3:0] ea;
        logic       ed;
        d  = ((cyc - t0) / int'(PRESCALE)) % int'(NDIG);
        ea = ~(4'b0001 << d);
        ed = !((d == 0) && exp_eq);
        cmp({tag, "_an"},    {4'h0, bus.an}, {4'h0, ea});
        cmp({tag, "_seg"},   {1'b0, bus.seg}, {1'b0, exp_seg[d]});
        cmp({tag, "_dp"},    {7'h0, bus.dp}, {7'h0, ed});
        cmp({tag, "_shown"}, {7'h0, bus.shown}, 8'h01);
    endtask

    task automatic set_exp(input logic [27:0] segs, input logic e);
        logic [27:0] s;
        s = segs;
        for (int i = 0; i < 4; i++) exp_seg[i] = s[7*i +: 7];
        exp_eq = e;
    endtask

    task automatic drive_load(input logic [15:0] b, input logic n, input logic e);
        bus.bcd_in = b;
        bus.neg_in = n;
        bus.eq_in  = e;
        bus.load   = 1'b1;
    endtask

    // Old data persists one more cycle after the strobe, new data from the second cycle on.
    task automatic reload(input string tag, input logic [15:0] b, input logic n, input logic e,
                          input logic [27:0] segs, input int ncheck);
        drive_load(b, n, e);
        tick();
        bus.load = 1'b0;
        check_scan({tag, "_hold"});
        set_exp(segs, e);
        for (int k = 0; k < ncheck; k++) begin
            tick();
            check_scan(tag);
        end
    endtask

    task automatic run_until(input string tag, input int idx, input bit want_tc);
        int guard;
        guard = 0;
        while (((((cyc + 1 - t0) / int'(PRESCALE)) % int'(NDIG)) != idx) ||
               (want_tc && (((cyc + 1 - t0) % int'(PRESCALE)) != int'(PRESCALE) - 1))) begin
            tick();
            check_scan(tag);
            guard++;
            if (guard > 64) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s_timeout observed=%0d expected=<=64", tag, guard);
                break;
            end
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        t0         = 0;
        exp_eq     = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.neg_in = 1'b0;
        bus.eq_in  = 1'b0;
        set_exp({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1'b0);

        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        for (int k = 0; k < 3 * int'(NDIG * PRESCALE); k++) begin
            tick();
            check_idle("idle");
        end

        // First load: -15 with leading blank and sign in digit 2.
        drive_load(16'h0015, 1'b1, 1'b0);
        tick();
        bus.load = 1'b0;
        cmp("first_shown", {7'h0, bus.shown}, 8'h01);
        cmp("first_an",    {4'h0, bus.an}, 8'h0F);
        t0 = cyc + 1;
        set_exp({7'h7F, 7'h3F, 7'h79, 7'h12}, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check_scan("neg15");
        end

        reload("zero_eq", 16'h0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16);
        reload("err_a",   16'h0A03, 1'b0, 1'b0, {7'h7F, 7'h06, 7'h40, 7'h30}, 16);

        // Reload while digit 2 is selected: full-width negative drops its sign.
        run_until("wait2", 2, 1'b0);
        reload("mid1234", 16'h1234, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 16);

        // Reload on the slot's terminal count: advance and new data together.
        run_until("waittc", 1, 1'b1);
        reload("tc_negz", 16'h0000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 16);

        // Reset and load in the same cycle: reset wins.
        run_until("wait3", 3, 1'b0);
        rst = 1'b1;
        drive_load(16'h0987, 1'b0, 1'b1);
        tick();
        rst      = 1'b0;
        bus.load = 1'b0;
        check_idle("rst_load");
        for (int k = 0; k < 8; k++) begin
            tick();
            check_idle("post_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
